alu_arbiter: RTL and testbench

Shares one combinational ALU (`alu_if`, `aluif` modport side) between two requesters, e.g. the execute stage (port 0) and a branch/address helper (port 1). Each requester submits operands and an aluop with a valid/ready handshake. The block arbitrates round-robin, registers the operands, and sequences one ALU evaluation. It then returns the result and flags on a registered, held response channel to the owning requester only.

---
 rtl/cpu_types_pkg.sv | 22 ++
 rtl/alu_arbiter_if.sv | 16 +
 rtl/alu_if.sv | 11 +
 rtl/alu.sv | 39 +++
 rtl/rr_arb2.sv | 22 ++
 rtl/alu_arbiter.sv | 111 +++++++++++
 tb/tb_alu_arbiter.sv | 241 ++++++++++++++++++++++++
 7 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word, ALU opcode, and the ALU arbiter state.
package cpu_types_pkg;
  localparam int WORD_W  = 32;
  localparam int NUM_REQ = 2;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  typedef enum logic [1:0] {ARB_IDLE, ARB_EXEC, ARB_RESP} aluarb_state_t;
endpackage

// File: rtl/alu_arbiter_if.sv
// Two-requester request/response bundle; master is the requester side.
interface alu_arbiter_if;
  import cpu_types_pkg::*;

  logic   [NUM_REQ-1:0] req_valid, req_ready;
  word_t  [NUM_REQ-1:0] req_a, req_b;
  aluop_t [NUM_REQ-1:0] req_op;
  logic   [NUM_REQ-1:0] resp_valid, resp_ready;
  word_t                resp_o;
  logic                 resp_zero, resp_ov, resp_neg;

  modport master (output req_valid, req_a, req_b, req_op, resp_ready,
                  input  req_ready, resp_valid, resp_o, resp_zero, resp_ov, resp_neg);
  modport slave  (input  req_valid, req_a, req_b, req_op, resp_ready,
                  output req_ready, resp_valid, resp_o, resp_zero, resp_ov, resp_neg);
endinterface

// File: rtl/alu_if.sv
// Combinational ALU port bundle: aluif is the ALU side, arb the driver side.
interface alu_if;
  import cpu_types_pkg::*;

  word_t  port_a, port_b, port_o;
  aluop_t aluop;
  logic   zero, ov, neg;

  modport aluif (input port_a, port_b, aluop, output port_o, zero, ov, neg);
  modport arb   (output port_a, port_b, aluop, input port_o, zero, ov, neg);
endinterface

// File: rtl/alu.sv
// Combinational 32-bit ALU with zero/overflow/negative flags.
module alu
  import cpu_types_pkg::*;
(
  alu_if.aluif aif
);
  word_t res;
  logic  ovf;

  // Result mux; overflow only meaningful for signed add/sub.
  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (aif.aluop)
      ALU_SLL:  res = aif.port_a << aif.port_b[4:0];
      ALU_SRL:  res = aif.port_a >> aif.port_b[4:0];
      ALU_ADD: begin
        res = aif.port_a + aif.port_b;
        ovf = (aif.port_a[31] == aif.port_b[31]) && (res[31] != aif.port_a[31]);
      end
      ALU_SUB: begin
        res = aif.port_a - aif.port_b;
        ovf = (aif.port_a[31] != aif.port_b[31]) && (res[31] != aif.port_a[31]);
      end
      ALU_AND:  res = aif.port_a & aif.port_b;
      ALU_OR:   res = aif.port_a | aif.port_b;
      ALU_XOR:  res = aif.port_a ^ aif.port_b;
      ALU_NOR:  res = ~(aif.port_a | aif.port_b);
      ALU_SLT:  res = {31'b0, $signed(aif.port_a) < $signed(aif.port_b)};
      ALU_SLTU: res = {31'b0, aif.port_a < aif.port_b};
      default:  res = '0;
    endcase
  end

  assign aif.port_o = res;
  assign aif.ov     = ovf;
  assign aif.neg    = res[31];
  assign aif.zero   = (res == '0);
endmodule

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin grant; the last-grant state lives in the caller.
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       last_i,
  output logic [1:0] gnt_o,
  output logic       gidx_o
);
  // Lone requester wins outright; on contention the port not granted last wins.
  always_comb begin
    gnt_o  = 2'b00;
    gidx_o = 1'b0;
    case (valid_i)
      2'b01: begin gnt_o = 2'b01; gidx_o = 1'b0; end
      2'b10: begin gnt_o = 2'b10; gidx_o = 1'b1; end
      2'b11: begin
        gidx_o = ~last_i;
        gnt_o  = last_i ? 2'b01 : 2'b10;
      end
      default: begin gnt_o = 2'b00; gidx_o = 1'b0; end
    endcase
  end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: round-robin accept,
// one registered evaluation cycle, then a held response to the owner only.
module alu_arbiter
  import cpu_types_pkg::*;
#(
  parameter logic RR_RESET_LAST = 1'b1
) (
  input  logic         CLK,
  input  logic         nRST,
  alu_arbiter_if.slave rif,
  alu_if.arb           aif
);
  aluarb_state_t state_q, state_d;
  logic          last_q, last_d;
  logic          owner_q, owner_d;
  word_t         opa_q, opa_d, opb_q, opb_d;
  aluop_t        op_q, op_d;
  word_t         res_q, res_d;
  logic          zero_q, zero_d, ov_q, ov_d, neg_q, neg_d;

  logic [1:0]    gnt;
  logic          gidx;
  logic          accept;

  rr_arb2 u_rr (
    .valid_i (rif.req_valid),
    .last_i  (last_q),
    .gnt_o   (gnt),
    .gidx_o  (gidx)
  );

  // Only IDLE can accept, so a consume in RESP never overlaps a new grant.
  assign rif.req_ready = (state_q == ARB_IDLE) ? gnt : 2'b00;
  assign accept        = |(rif.req_valid & rif.req_ready);

  // ALU is fed purely from the operand registers, never from requester inputs.
  assign aif.port_a = opa_q;
  assign aif.port_b = opb_q;
  assign aif.aluop  = op_q;

  // Response comes only from registers, so ALU activity cannot disturb it.
  assign rif.resp_valid = (state_q == ARB_RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign rif.resp_o     = res_q;
  assign rif.resp_zero  = zero_q;
  assign rif.resp_ov    = ov_q;
  assign rif.resp_neg   = neg_q;

  // Next-state: accept in IDLE, sample ALU in EXEC, wait for owner in RESP.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    op_d    = op_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ov_d    = ov_q;
    neg_d   = neg_q;
    case (state_q)
      ARB_IDLE: begin
        if (accept) begin
          opa_d   = rif.req_a[gidx];
          opb_d   = rif.req_b[gidx];
          op_d    = rif.req_op[gidx];
          owner_d = gidx;
          last_d  = gidx;
          state_d = ARB_EXEC;
        end
      end
      ARB_EXEC: begin
        res_d   = aif.port_o;
        zero_d  = aif.zero;
        ov_d    = aif.ov;
        neg_d   = aif.neg;
        state_d = ARB_RESP;
      end
      ARB_RESP: begin
        if (rif.resp_ready[owner_q]) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ARB_IDLE;
      last_q  <= RR_RESET_LAST;
      owner_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      op_q    <= aluop_t'(4'd0);
      res_q   <= '0;
      zero_q  <= 1'b0;
      ov_q    <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      op_q    <= op_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ov_q    <= ov_d;
      neg_q   <= neg_d;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter driving the real alu through alu_if.
module tb_alu_arbiter;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST;
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  alu_arbiter_if rif ();
  alu_if         aif ();

  alu u_alu (.aif(aif.aluif));

  alu_arbiter #(.RR_RESET_LAST(1'b1)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .rif  (rif.slave),
    .aif  (aif.arb)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int     port;
    aluop_t op;
    word_t  a, b, o;
    logic   z, v, n;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_grant(input string nm);
    int n = 0;
    while (rif.req_ready == 2'b00 && n < 10) begin
      tick(); #1; n++;
    end
    if (rif.req_ready == 2'b00) begin
      n_vec++; n_bad++;
      $display("FAIL %s: no grant within 10 cycles", nm);
    end
  endtask

  function automatic logic [31:0] flags();
    return 32'({rif.resp_zero, rif.resp_ov, rif.resp_neg});
  endfunction

  // One isolated request on one port, from IDLE through consumption.
  task automatic run_vec(input vec_t v);
    logic [1:0] m;
    m = (v.port == 1) ? 2'b10 : 2'b01;
    rif.req_a[v.port]  = v.a;
    rif.req_b[v.port]  = v.b;
    rif.req_op[v.port] = v.op;
    rif.req_valid      = m;
    #1;
    chk("vec_ready", 32'(rif.req_ready), 32'(m));
    tick();
    rif.req_valid = 2'b00;
    chk("vec_alu_a", aif.port_a, v.a);
    chk("vec_alu_op", 32'(aif.aluop), 32'(v.op));
    chk("vec_exec_rv", 32'(rif.resp_valid), 32'd0);
    tick();
    chk("vec_resp_valid", 32'(rif.resp_valid), 32'(m));
    chk("vec_resp_o", rif.resp_o, v.o);
    chk("vec_flags", flags(), 32'({v.z, v.v, v.n}));
    rif.resp_ready = m;
    tick();
    rif.resp_ready = 2'b00;
    chk("vec_done_rv", 32'(rif.resp_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc_prev;
    vt[0] = '{0, ALU_ADD, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1, ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b1};
    vt[2] = '{0, ALU_SUB, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vt[3] = '{1, ALU_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1};
    vt[4] = '{0, ALU_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0, 1'b0};
    vt[5] = '{1, ALU_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
    vt[6] = '{0, ALU_XOR, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vt[7] = '{1, ALU_OR,  32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b0};

    nRST           = 1'b0;
    rif.req_valid  = 2'b00;
    rif.resp_ready = 2'b00;
    for (int i = 0; i < 2; i++) begin
      rif.req_a[i]  = '0;
      rif.req_b[i]  = '0;
      rif.req_op[i] = ALU_SLL;
    end

    // reset values
    #3;
    chk("rst_req_ready", 32'(rif.req_ready), 32'd0);
    chk("rst_resp_valid", 32'(rif.resp_valid), 32'd0);
    chk("rst_resp_o", rif.resp_o, 32'd0);
    chk("rst_flags", flags(), 32'd0);
    chk("rst_alu_b", aif.port_b, 32'd0);
    #19 nRST = 1'b1;
    tick();

    // table-driven single requests
    for (int i = 0; i < 8; i++) run_vec(vt[i]);

    // response backpressure with port 1 waiting and its resp_ready ignored
    rif.req_a[0] = 32'd5; rif.req_b[0] = 32'd3; rif.req_op[0] = ALU_ADD;
    rif.req_valid = 2'b01;
    #1;
    tick();
    rif.req_valid = 2'b00;
    tick();
    rif.req_a[1] = 32'd2; rif.req_b[1] = 32'd2; rif.req_op[1] = ALU_ADD;
    rif.req_valid  = 2'b10;
    rif.resp_ready = 2'b10;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_req_ready", 32'(rif.req_ready), 32'd0);
      chk("bp_resp_valid", 32'(rif.resp_valid), 32'h1);
      chk("bp_resp_o", rif.resp_o, 32'd8);
      chk("bp_flags", flags(), 32'd0);
      tick();
    end
    rif.resp_ready = 2'b11;
    #1;
    chk("bp_ready_consume_cycle", 32'(rif.req_ready), 32'd0);
    tick();
    rif.resp_ready = 2'b10;
    #1;
    chk("bp_grant_p1", 32'(rif.req_ready), 32'h2);
    tick();
    rif.req_valid = 2'b00;
    chk("bp_p1_alu_a", aif.port_a, 32'd2);
    tick();
    chk("bp_p1_resp_valid", 32'(rif.resp_valid), 32'h2);
    chk("bp_p1_resp_o", rif.resp_o, 32'd4);
    tick();
    rif.resp_ready = 2'b00;
    chk("bp_p1_done", 32'(rif.resp_valid), 32'd0);

    // withdrawn request during RESP: last stays at port 0
    rif.req_a[0] = 32'd1; rif.req_b[0] = 32'd2; rif.req_op[0] = ALU_ADD;
    rif.req_valid = 2'b01;
    #1;
    tick();
    rif.req_valid = 2'b00;
    tick();
    rif.req_valid = 2'b10;
    #1;
    chk("wd_ready_in_resp", 32'(rif.req_ready), 32'd0);
    #2 rif.req_valid = 2'b00;
    rif.resp_ready = 2'b01;
    tick();
    rif.resp_ready = 2'b00;
    #1;
    chk("wd_no_grant", 32'(rif.req_ready), 32'd0);
    chk("wd_no_resp", 32'(rif.resp_valid), 32'd0);
    tick();
    #1;
    chk("wd_still_idle_no_grant", 32'(rif.resp_valid | rif.req_ready), 32'd0);
    rif.req_valid = 2'b11;
    #1;
    chk("wd_last_unchanged", 32'(rif.req_ready), 32'h2);
    rif.req_valid = 2'b00;
    tick();

    // asynchronous reset in the middle of RESP
    rif.req_a[0] = 32'd5; rif.req_b[0] = 32'd3; rif.req_op[0] = ALU_ADD;
    rif.req_valid = 2'b01;
    #1;
    tick();
    rif.req_valid = 2'b00;
    tick();
    chk("mr_pre_resp_valid", 32'(rif.resp_valid), 32'h1);
    #2 nRST = 1'b0;
    #1;
    chk("mr_resp_valid", 32'(rif.resp_valid), 32'd0);
    chk("mr_resp_o", rif.resp_o, 32'd0);
    chk("mr_flags", flags(), 32'd0);
    chk("mr_alu_a", aif.port_a, 32'd0);
    chk("mr_alu_b", aif.port_b, 32'd0);
    chk("mr_alu_op", 32'(aif.aluop), 32'd0);
    chk("mr_req_ready", 32'(rif.req_ready), 32'd0);
    #2 nRST = 1'b1;
    tick();
    #1;
    chk("mr_post_ready_idle", 32'(rif.req_ready), 32'd0);
    rif.req_valid = 2'b01;
    #1;
    chk("mr_post_in_idle", 32'(rif.req_ready), 32'h1);
    rif.req_valid = 2'b00;
    tick();

    // contention fairness, both ports valid continuously
    rif.req_a[0] = 32'd7; rif.req_b[0] = 32'd7; rif.req_op[0] = ALU_SUB;
    rif.req_a[1] = 32'd1; rif.req_b[1] = 32'd1; rif.req_op[1] = ALU_ADD;
    rif.resp_ready = 2'b11;
    rif.req_valid  = 2'b11;
    acc_prev = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      wait_grant("cont_wait");
      chk("cont_grant", 32'(rif.req_ready), (k % 2 == 1) ? 32'h2 : 32'h1);
      tick();
      if (k > 0) chk("cont_interval", 32'(cyc - acc_prev), 32'd3);
      acc_prev = cyc;
      tick();
      chk("cont_resp_valid", 32'(rif.resp_valid), (k % 2 == 1) ? 32'h2 : 32'h1);
      chk("cont_resp_o", rif.resp_o, (k % 2 == 1) ? 32'd2 : 32'd0);
      chk("cont_zero", 32'(rif.resp_zero), (k % 2 == 1) ? 32'd0 : 32'd1);
      tick();
    end
    rif.req_valid  = 2'b00;
    rif.resp_ready = 2'b00;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
